bitvec_build: RTL and testbench
===============================

Name: bitvec_build

Overview:
- Inverse of the find-first-one scan: accepts a stream of bit indexes and rebuilds the bit vector they describe.
- Emits the completed vector through a valid/ready handshake.
- Used to reconstruct ready/valid masks from index streams produced by the find-first-one encoders, e.g. issue-queue wakeup and free-list release.
- Index sentinel is all-ones, matching the encoders' "no bit found" output.

Parameters:
- WID, 144, vector width in bits.
- IW, 8, index width; must satisfy 2**IW > WID.
- CW, 8, count width; must satisfy 2**CW > WID.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- clr  in  1  synchronous abort/clear; any state.
- idx_valid  in  1  index present.
- idx_ready  out  1  block accepts index.
- idx  in  IW  bit index; all-ones = none.
- idx_last  in  1  final index of this vector.
- vec_valid  out  1  vector complete.
- vec_ready  in  1  consumer takes vector.
- vec  out  WID  accumulated vector.
- vec_count  out  CW  number of distinct bits set.
- err_range  out  1  sticky: index >= WID and not sentinel.
- err_dup  out  1  sticky: index already set.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_n sampled on the rising clk edge).
- Reset values: state=ACCUM, vec=0, vec_count=0, vec_valid=0, err_range=0, err_dup=0. idx_ready=0 while rst_n is low.
- States:
  - ACCUM: idx_ready=1, vec_valid=0.
  - HOLD: idx_ready=0, vec_valid=1.
  - Both outputs decode from the state register only; no combinational path from any input.
- Accept: idx_valid & idx_ready at edge t. Effect is visible at t+1.
  - idx == all-ones: no bit change, no count change, no error.
  - WID <= idx < all-ones: vec unchanged, err_range <= 1.
  - vec[idx] already 1: vec unchanged, count unchanged, err_dup <= 1.
  - Otherwise: vec[idx] <= 1, vec_count <= vec_count + 1.
- idx_last on an accepted beat: the beat is applied as above in all cases, including sentinel or error beats, and state <= HOLD. vec_valid=1 at t+1, and vec includes that beat.
- idx_last without idx_valid: ignored.
- Throughput: one index per cycle in ACCUM; no bubbles between indexes.
- HOLD: vec, vec_count and the error flags are stable. On vec_valid & vec_ready at an edge:
  - vec, vec_count, err_range and err_dup clear to 0.
  - state <= ACCUM.
  - idx_ready=1 on the next cycle (one dead cycle between vectors).
- HOLD with vec_ready=0: hold indefinitely; idx_valid is ignored (no accept).
- clr=1 at an edge, any state:
  - vec, vec_count and the flags go to 0; state <= ACCUM.
  - clr has priority over a simultaneous index accept; that index is dropped.
  - A simultaneous vec handshake in HOLD still counts as a transfer for the consumer, since the outputs were valid that cycle. The contents are then cleared.
- Errors: err_range and err_dup are sticky until handshake, clr or reset. They are valid alongside vec while vec_valid=1.
- Count width: vec_count never wraps, because duplicates are not counted and at most WID distinct bits exist.
- Reset mid-operation: rst_n=0 overrides clr and all handshakes. Any partial vector is discarded.

Test Plan:
1. Reset, then send indexes 5, 143, 0 (last on 0) -> vec_valid=1 one cycle after last; vec has bits 0, 5, 143; vec_count=3; no errors; vec_ready=1 -> vec=0 and idx_ready=1 on the next cycle.
2. Send 7, 7, 200, 255 (last) -> vec has bit 7 only; vec_count=1; err_dup=1; err_range=1 (for 200); the sentinel 255 changes nothing.
3. Back-to-back indexes 0..143 one per cycle, last on 143 -> idx_ready never drops before last; vec all-ones; vec_count=144; HOLD entered exactly 1 cycle after the last accept.
4. In HOLD with vec_ready=0 for 10 cycles and idx_valid=1 with idx=3 -> vec, count and flags unchanged; idx_ready=0; no accept occurs.
5. Mid-vector (bits 1 and 2 set), assert clr together with idx_valid on idx=9 -> next cycle vec=0, count=0, state ACCUM; index 9 is not recorded.
6. Mid-vector, drive rst_n=0 for one cycle with idx_valid=1 -> all outputs at reset values; idx_ready=0 during reset and 1 the cycle after release.

Source files
------------

// File: rtl/bitvec_build_if.sv
// Handshake bundle for bitvec_build.
//   Index side : idx_valid/idx_ready carry idx (all-ones = no bit) and idx_last.
//   Vector side: vec_valid/vec_ready carry vec, vec_count, err_range, err_dup.
// The slave modport is the block itself. The master modport is the
// producer/consumer that drives indexes and takes vectors.
interface bitvec_build_if #(
  parameter int unsigned WID = 144,
  parameter int unsigned IW  = 8,
  parameter int unsigned CW  = 8
);
  logic          idx_valid;
  logic          idx_ready;
  logic [IW-1:0] idx;
  logic          idx_last;
  logic           vec_valid;
  logic           vec_ready;
  logic [WID-1:0] vec;
  logic [CW-1:0]  vec_count;
  logic           err_range;
  logic           err_dup;

  modport slave (
    input  idx_valid, idx, idx_last, vec_ready,
    output idx_ready, vec_valid, vec, vec_count, err_range, err_dup
  );

  modport master (
    output idx_valid, idx, idx_last, vec_ready,
    input  idx_ready, vec_valid, vec, vec_count, err_range, err_dup
  );
endinterface

// File: rtl/bitvec_build.sv
// bitvec_build: rebuilds a bit vector from a stream of bit indexes.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   clr   : synchronous abort; empties the vector and returns to ACCUM
//   bus   : slave side of bitvec_build_if (index stream in, vector out)
// In ACCUM the block takes one index per cycle. An index beat with idx_last
// moves it to HOLD. In HOLD the vector, count and sticky error flags are
// presented until the consumer takes them, and then everything clears.
module bitvec_build #(
  parameter int unsigned WID = 144,
  parameter int unsigned IW  = 8,
  parameter int unsigned CW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  bitvec_build_if.slave   bus
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [IW-1:0] SENTINEL = '1;
  localparam logic [IW-1:0] WID_IDX  = IW'(WID);

  state_e         state_q, state_d;
  logic [WID-1:0] vec_q, vec_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_range_q, err_range_d;
  logic           err_dup_q, err_dup_d;
  logic           accept;

  // Outputs decode from the state register. rst_n also gates idx_ready
  // so that no index looks acceptable while reset is held.
  assign bus.idx_ready = (state_q == ACCUM) && rst_n;
  assign bus.vec_valid = (state_q == HOLD);
  assign bus.vec       = vec_q;
  assign bus.vec_count = cnt_q;
  assign bus.err_range = err_range_q;
  assign bus.err_dup   = err_dup_q;

  assign accept = bus.idx_valid && (state_q == ACCUM);

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    err_range_d = err_range_q;
    err_dup_d   = err_dup_q;

    if (accept) begin
      if (bus.idx == SENTINEL) begin
        // no-bit marker: the beat carries only idx_last
      end else if (bus.idx >= WID_IDX) begin
        err_range_d = 1'b1;
      end else if (vec_q[bus.idx]) begin
        err_dup_d = 1'b1;
      end else begin
        vec_d[bus.idx] = 1'b1;
        cnt_d          = cnt_q + CW'(1);
      end
      if (bus.idx_last) state_d = HOLD;
    end

    // The handshake and clr both empty the vector. If they coincide in HOLD,
    // the consumer has already sampled the valid contents, so clr only
    // has to clear.
    if ((state_q == HOLD && bus.vec_ready) || clr) begin
      state_d     = ACCUM;
      vec_d       = '0;
      cnt_d       = '0;
      err_range_d = 1'b0;
      err_dup_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      vec_q       <= '0;
      cnt_q       <= '0;
      err_range_q <= 1'b0;
      err_dup_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      err_range_q <= err_range_d;
      err_dup_q   <= err_dup_d;
    end
  end

endmodule

// File: tb/tb_bitvec_build.sv
// Directed testbench for bitvec_build. Inputs change 1 ns after the rising
// edge, and outputs are checked at that same point.
module tb_bitvec_build;

  localparam int unsigned WID = 144;
  localparam int unsigned IW  = 8;
  localparam int unsigned CW  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bitvec_build_if #(.WID(WID), .IW(IW), .CW(CW)) bus ();

  bitvec_build #(.WID(WID), .IW(IW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] i, input logic last);
    bus.idx_valid = 1'b1;
    bus.idx       = i;
    bus.idx_last  = last;
    tick();
    bus.idx_valid = 1'b0;
    bus.idx_last  = 1'b0;
  endtask

  task automatic take();
    bus.vec_ready = 1'b1;
    tick();
    bus.vec_ready = 1'b0;
  endtask

  logic [WID-1:0] ev;
  logic [WID-1:0] ones;

  initial begin
    ones          = '1;
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.idx_valid = 1'b0;
    bus.idx       = '0;
    bus.idx_last  = 1'b0;
    bus.vec_ready = 1'b0;
    tick();
    tick();
    chk("rst_idx_ready", bus.idx_ready, 0);
    chk("rst_vec_valid", bus.vec_valid, 0);
    chk("rst_vec", bus.vec, 0);
    chk("rst_count", bus.vec_count, 0);
    chk("rst_err_range", bus.err_range, 0);
    chk("rst_err_dup", bus.err_dup, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_idx_ready", bus.idx_ready, 1);
    tick();

    // 1: indexes 5, 143, 0 (last)
    send(8'd5, 1'b0);
    chk("t1_valid_early", bus.vec_valid, 0);
    send(8'd143, 1'b0);
    send(8'd0, 1'b1);
    ev = '0; ev[0] = 1'b1; ev[5] = 1'b1; ev[143] = 1'b1;
    chk("t1_vec_valid", bus.vec_valid, 1);
    chk("t1_idx_ready", bus.idx_ready, 0);
    chk("t1_vec", bus.vec, ev);
    chk("t1_count", bus.vec_count, 3);
    chk("t1_err_range", bus.err_range, 0);
    chk("t1_err_dup", bus.err_dup, 0);
    take();
    chk("t1_clr_vec", bus.vec, 0);
    chk("t1_clr_count", bus.vec_count, 0);
    chk("t1_clr_valid", bus.vec_valid, 0);
    chk("t1_idx_ready_after", bus.idx_ready, 1);

    // 2: duplicate, out-of-range, sentinel
    send(8'd7, 1'b0);
    send(8'd7, 1'b0);
    chk("t2_dup_early", bus.err_dup, 1);
    chk("t2_range_early", bus.err_range, 0);
    send(8'd200, 1'b0);
    send(8'd255, 1'b1);
    ev = '0; ev[7] = 1'b1;
    chk("t2_vec_valid", bus.vec_valid, 1);
    chk("t2_vec", bus.vec, ev);
    chk("t2_count", bus.vec_count, 1);
    chk("t2_err_dup", bus.err_dup, 1);
    chk("t2_err_range", bus.err_range, 1);
    take();
    chk("t2_clr_dup", bus.err_dup, 0);
    chk("t2_clr_range", bus.err_range, 0);

    // 3: back-to-back fill 0..143
    for (int i = 0; i < 144; i++) begin
      bus.idx_valid = 1'b1;
      bus.idx       = IW'(i);
      bus.idx_last  = (i == 143);
      chk($sformatf("t3_ready_%0d", i), bus.idx_ready, 1);
      tick();
    end
    bus.idx_valid = 1'b0;
    bus.idx_last  = 1'b0;
    chk("t3_vec_valid", bus.vec_valid, 1);
    chk("t3_vec", bus.vec, ones);
    chk("t3_count", bus.vec_count, 144);
    chk("t3_err_dup", bus.err_dup, 0);

    // 4: HOLD with back-pressure, index offered but not taken
    bus.idx_valid = 1'b1;
    bus.idx       = 8'd3;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t4_idx_ready", bus.idx_ready, 0);
      chk("t4_vec_valid", bus.vec_valid, 1);
      chk("t4_vec", bus.vec, ones);
      chk("t4_count", bus.vec_count, 144);
      chk("t4_err_dup", bus.err_dup, 0);
    end
    bus.idx_valid = 1'b0;
    take();
    chk("t4_after_take_valid", bus.vec_valid, 0);
    chk("t4_after_take_vec", bus.vec, 0);

    // 5: clr overrides a simultaneous accept
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    chk("t5_partial_vec", bus.vec, 6);
    chk("t5_partial_count", bus.vec_count, 2);
    clr           = 1'b1;
    bus.idx_valid = 1'b1;
    bus.idx       = 8'd9;
    tick();
    clr           = 1'b0;
    bus.idx_valid = 1'b0;
    chk("t5_vec", bus.vec, 0);
    chk("t5_count", bus.vec_count, 0);
    chk("t5_idx_ready", bus.idx_ready, 1);
    chk("t5_vec_valid", bus.vec_valid, 0);
    send(8'd4, 1'b1);
    chk("t5_next_vec", bus.vec, 16);
    chk("t5_next_count", bus.vec_count, 1);
    chk("t5_next_valid", bus.vec_valid, 1);
    take();

    // 6: reset mid-vector
    send(8'd1, 1'b0);
    chk("t6_partial", bus.vec, 2);
    rst_n         = 1'b0;
    bus.idx_valid = 1'b1;
    bus.idx       = 8'd3;
    #1;
    chk("t6_ready_in_rst", bus.idx_ready, 0);
    tick();
    chk("t6_vec", bus.vec, 0);
    chk("t6_count", bus.vec_count, 0);
    chk("t6_valid", bus.vec_valid, 0);
    chk("t6_ready_low", bus.idx_ready, 0);
    rst_n         = 1'b1;
    bus.idx_valid = 1'b0;
    #1;
    chk("t6_ready_release", bus.idx_ready, 1);
    tick();
    chk("t6_vec_after", bus.vec, 0);
    chk("t6_flags_after", {bus.err_range, bus.err_dup}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
